lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Receive-side counterpart of the team's Fibonacci LFSR generator. It consumes the serial bit stream that the generator emits and self-synchronises to it: each new bit is the generator's feedback bit, which lands in lfsr_out[0]. Once synchronised, it flags and counts every bit that differs from the predicted sequence. It sits at the sink end of PRBS link and BIST paths, with the generator at the source end.

## Interface
- WIDTH, 32, LFSR length; must match the generator.
- TAPS, 32'h80200003, feedback tap mask; must match the generator.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- LOSS_COUNT, 8, consecutive mispredictions in lock that force resync.
- CNT_W, 16, error counter width.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is sampled only when high; no backpressure.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  checker is synchronised (state LOCKED).
- err_pulse  out  1  one-cycle pulse: the bit sampled on the previous edge mismatched while LOCKED.
- err_count  out  CNT_W  saturating count of mismatches seen while LOCKED.

## Operation
- Internal shadow register sreg[WIDTH-1:0]. Predicted bit p = ^(sreg & TAPS).
- Shift rule per valid bit: sreg <= {sreg[WIDTH-2:0], x}.
  - In HUNT and VERIFY, x = bit_in.
  - In LOCKED, x = p. This stops single errors from propagating into later predictions.
- The state machine, enum HUNT / VERIFY / LOCKED, advances only on valid bits.
  - HUNT: fill counter counts valid bits. After the WIDTH-th bit:
    - if the new sreg is nonzero, go to VERIFY with match count 0;
    - if it is all zero, restart the fill and stay in HUNT. The generator never emits the zero state, so this prevents a false lock on a stuck-0 line.
  - VERIFY: a valid bit with bit_in == p increments the match count. At LOCK_COUNT matches, go to LOCKED. A mismatch returns to HUNT with the fill counter at 0.
  - LOCKED: a mismatch asserts err_pulse, increments err_count and increments the loss counter. A match clears the loss counter. When the loss counter reaches LOSS_COUNT, go to HUNT with the fill counter at 0.
- err_count saturates at 2^CNT_W-1.
- err_clr alone loads err_count with 0.
- err_clr in the same cycle as a counted error loads err_count with 1: the error is not lost.
- Cycles without bit_valid hold all state and drive err_pulse to 0.

## Timing
- All outputs are registered.
- Reset values: locked=0, err_pulse=0, err_count=0, state=HUNT, sreg=0, all counters 0.
- rst asserted in any state, mid-operation included, returns every register to its reset value on the next edge.
- err_pulse goes high on the edge that samples the erroneous bit and lasts exactly one cycle, unless the next valid bit also errs.
- locked rises on the edge that samples the LOCK_COUNT-th matching bit in VERIFY. From a clean start with contiguous valid bits this is the WIDTH+LOCK_COUNT-th bit (48 at defaults).
- locked falls on the edge that samples the LOSS_COUNT-th consecutive mismatch. That mismatch is also counted and pulsed.
- Throughput is one bit per clock. No stall conditions exist.

## Structure
- Package lfsr_pkg holds:
  - the default WIDTH and TAPS constants, shared with the generator;
  - the checker state enum.
- Sub-module lfsr_next_bit is the combinational parity of (state & TAPS). It is natural to share this with the generator so that both ends use an identical feedback definition.
- The checker top holds the FSM, sreg, the fill, match and loss counters, and the error counter.

## Test plan
- Reset: hold rst for 3 cycles with random bit_in. Required: locked=0, err_pulse=0, err_count=0 throughout and on the first cycle after release.
- Clean lock: drive the generator stream (seed 32'h1, first bits 1,0,1,1,0,…) with bit_valid=1 every cycle. Required:
  - locked rises on the edge of the 48th bit;
  - err_count stays 0 over 2000 bits.
- Single error: once LOCKED, invert one bit. Required:
  - exactly one err_pulse cycle;
  - err_count=1 and locked stays 1;
  - no further errors over the next 200 bits.
- Loss of sync: once LOCKED, invert 8 consecutive bits. Required:
  - locked drops on the 8th inverted bit with err_count=8;
  - after clean bits resume, locked returns after 48 more valid bits.
- Degenerate input: all-zero stream for 500 bits. Required: locked never asserts and err_count=0.
- Corner cases:
  - random bit_valid gaps (≈50% duty) still lock after 48 valid bits;
  - err_clr together with an error gives err_count=1;
  - forcing err_count to 16'hFFFF and then injecting an error holds it at 16'hFFFF;
  - rst mid-LOCKED clears all outputs on the next edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR constants and checker state type
package lfsr_pkg;

  // Defaults shared with the generator so both ends agree on the polynomial.
  localparam int unsigned LFSR_WIDTH = 32;
  localparam logic [31:0] LFSR_TAPS  = 32'h80200003;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lfsr_next_bit.sv
// rtl/lfsr_next_bit.sv - Fibonacci LFSR feedback bit (parity of tapped state)
module lfsr_next_bit
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic [WIDTH-1:0] state_i,
  output logic             bit_o
);

  // Feedback is the XOR of every tapped state bit.
  assign bit_o = ^(state_i & TAPS);

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker with error counting
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = LFSR_TAPS,
  parameter int unsigned      LOCK_COUNT = 16,
  parameter int unsigned      LOSS_COUNT = 8,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned LOSS_W  = $clog2(LOSS_COUNT + 1);

  chk_state_e          state_q, state_d;
  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q;
  logic                err_evt;
  logic                pred;
  logic                mismatch;

  lfsr_next_bit #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next_bit (
    .state_i (sreg_q),
    .bit_o   (pred)
  );

  assign mismatch = bit_in ^ pred;

  // Sync FSM: fill the shadow register, verify predictions, then track errors.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    fill_d  = fill_q;
    match_d = match_q;
    loss_d  = loss_q;
    err_evt = 1'b0;
    if (bit_valid) begin
      case (state_q)
        HUNT: begin
          sreg_d = {sreg_q[WIDTH-2:0], bit_in};
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            fill_d = '0;
            // An all-zero fill is a dead line, never a valid generator state.
            if (sreg_d != '0) begin
              state_d = VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          sreg_d = {sreg_q[WIDTH-2:0], bit_in};
          if (!mismatch) begin
            if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              loss_d  = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            state_d = HUNT;
            fill_d  = '0;
          end
        end
        LOCKED: begin
          // Self-feed the prediction so a bad bit never corrupts later ones.
          sreg_d = {sreg_q[WIDTH-2:0], pred};
          if (mismatch) begin
            err_evt = 1'b1;
            if (loss_q == LOSS_W'(LOSS_COUNT - 1)) begin
              state_d = HUNT;
              fill_d  = '0;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + LOSS_W'(1);
            end
          end else begin
            loss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Saturating error counter; a clear coinciding with an error keeps that error.
  always_comb begin
    err_count_d = err_count_q;
    if (err_evt) begin
      if (err_clr) begin
        err_count_d = CNT_W'(1);
      end else if (!(&err_count_q)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_count_d = '0;
    end
  end

  assign locked_d = (state_d == LOCKED);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      sreg_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      loss_q      <= '0;
      err_count_q <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      loss_q      <= loss_d;
      err_count_q <= err_count_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_evt;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - self-checking bench for lfsr_checker
module tb_lfsr_checker;

  localparam logic [31:0] G_TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        err_clr;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Behavioural expectation: mode 0=hunting, 1=verifying, 2=locked.
  int          m_mode  = 0;
  logic [31:0] m_hist  = '0;
  int          m_fill  = 0;
  int          m_match = 0;
  int          m_loss  = 0;
  int          m_cnt   = 0;
  bit          m_pulse = 1'b0;
  bit          m_locked = 1'b0;

  logic [31:0] g;

  lfsr_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic gen_bit(output logic b);
    b = ^(g & G_TAPS);
    g = {g[30:0], b};
  endtask

  task automatic model_step();
    logic p;
    bit   err;
    err = 1'b0;
    if (rst) begin
      m_mode = 0; m_hist = '0; m_fill = 0; m_match = 0; m_loss = 0; m_cnt = 0;
    end else begin
      if (bit_valid) begin
        p = ^(m_hist & G_TAPS);
        if (m_mode == 2) begin
          m_hist = {m_hist[30:0], p};
          if (bit_in != p) begin
            err = 1'b1;
            m_loss++;
            if (m_loss == 8) begin m_mode = 0; m_fill = 0; end
          end else begin
            m_loss = 0;
          end
        end else begin
          m_hist = {m_hist[30:0], bit_in};
          if (m_mode == 0) begin
            m_fill++;
            if (m_fill == 32) begin
              m_fill = 0;
              if (m_hist != 0) begin m_mode = 1; m_match = 0; end
            end
          end else if (bit_in == p) begin
            m_match++;
            if (m_match == 16) begin m_mode = 2; m_loss = 0; end
          end else begin
            m_mode = 0; m_fill = 0;
          end
        end
      end
      if (err) m_cnt = err_clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
      else if (err_clr) m_cnt = 0;
    end
    m_pulse  = err;
    m_locked = (m_mode == 2);
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    bit_in = b; bit_valid = v; err_clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_locked", locked, m_locked);
      check("cyc_err_pulse", err_pulse, m_pulse);
      check("cyc_err_count", err_count, m_cnt);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic       b;
    logic [4:0] first;
    int         n, lock_at, pulses, nv, cyc;
    bit         ever_locked;

    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; err_clr = 1'b0;
    // Reset with random data.
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom), 1'b1, 1'b0);
      cmp_en = 1'b1;
      check("rst_locked", locked, 0);
      check("rst_err_count", err_count, 0);
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_locked", locked, 0);
    check("post_rst_pulse", err_pulse, 0);

    // Pin the generator: seed 1 gives 1,0,1,1,0.
    g = 32'h1;
    for (int i = 0; i < 5; i++) begin gen_bit(b); first[4-i] = b; end
    check("gen_first_bits", first, 5'b10110);

    // Clean lock and long clean run.
    g = 32'h1;
    lock_at = 0;
    for (int i = 1; i <= 2000; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      if (locked && lock_at == 0) lock_at = i;
    end
    check("lock_bit_index", lock_at, 48);
    check("clean_err_count", err_count, 0);
    check("clean_locked", locked, 1);

    // Single inverted bit.
    pulses = 0;
    gen_bit(b);
    step(~b, 1'b1, 1'b0);
    if (err_pulse) pulses++;
    for (int i = 0; i < 200; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      if (err_pulse) pulses++;
    end
    check("single_pulses", pulses, 1);
    check("single_err_count", err_count, 1);
    check("single_locked", locked, 1);

    // Clear alone.
    step(1'b0, 1'b0, 1'b1);
    check("clr_alone", err_count, 0);

    // Eight consecutive errors drop lock.
    for (int k = 1; k <= 8; k++) begin
      gen_bit(b);
      step(~b, 1'b1, 1'b0);
      if (k == 7) check("loss_still_locked_7", locked, 1);
    end
    check("loss_locked", locked, 0);
    check("loss_err_count", err_count, 8);
    check("loss_pulse", err_pulse, 1);
    n = 0;
    while (!locked && n < 200) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0);
      n++;
    end
    check("relock_bits", n, 48);

    // Clear together with an error keeps the error.
    gen_bit(b);
    step(~b, 1'b1, 1'b1);
    check("clr_with_err_count", err_count, 1);
    check("clr_with_err_pulse", err_pulse, 1);
    gen_bit(b);
    step(b, 1'b1, 1'b0);

    // Saturation.
    force dut.err_count_q = 16'hFFFF;
    m_cnt = 65535;
    step(1'b0, 1'b0, 1'b0);
    release dut.err_count_q;
    gen_bit(b);
    step(~b, 1'b1, 1'b0);
    check("sat_err_count", err_count, 16'hFFFF);
    check("sat_pulse", err_pulse, 1);

    // Reset while locked, on a cycle that would otherwise flag an error.
    check("pre_rst_locked", locked, 1);
    rst = 1'b1;
    gen_bit(b);
    step(~b, 1'b1, 1'b0);
    check("midrst_locked", locked, 0);
    check("midrst_pulse", err_pulse, 0);
    check("midrst_count", err_count, 0);
    rst = 1'b0;

    // Stuck-zero line.
    ever_locked = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (locked) ever_locked = 1'b1;
    end
    check("zero_never_locked", ever_locked, 0);
    check("zero_err_count", err_count, 0);

    // Gappy valid stream.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    g = 32'h1;
    nv = 0; cyc = 0;
    while (!locked && cyc < 2000) begin
      if ($urandom_range(1, 0) == 1) begin
        gen_bit(b);
        step(b, 1'b1, 1'b0);
        nv++;
      end else begin
        step(1'($urandom), 1'b0, 1'b0);
      end
      cyc++;
    end
    check("gappy_lock_valid_bits", nv, 48);
    check("gappy_locked", locked, 1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
